// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap entry / MRET sequencer for the exec stage of a
//   single-hart, M-mode-only core.
//
//   Flow:  IDLE -> DRAIN -> UPDATE -> [CHAIN] -> REDIRECT -> IDLE
//     IDLE     : arbitrate exception > enabled interrupt > MRET
//     DRAIN    : hold flush_req until the pipeline is empty
//     UPDATE   : one-cycle CSR strobe (trap_do_update or xret_do_update)
//     CHAIN    : one-cycle trap strobe for an interrupt that becomes
//                takeable as a consequence of the MRET just performed
//     REDIRECT : fetch redirect, valid/ready handshake
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   mstatus/mie/mip/mtvec/mepc  current CSR values
//   privilege_mode              current privilege level
//   exc_valid/cause/pc/tval     synchronous exception request (held to ack)
//   mret_valid                  MRET request (held to ack)
//   next_pc                     PC of the oldest unretired instr (intr mepc)
//   exc_ack                     one-cycle accept pulse for exc / MRET
//   flush_req, pipeline_empty   drain request / drain done
//   trap_*                      CSR trap-entry update strobe and values
//   xret_*                      CSR MRET update strobe and values
//   redirect_valid/pc/ready     fetch redirect handshake
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int XLEN              = 64,
  parameter int ALEN              = 64,
  parameter int INTR_LEN          = 64,
  parameter int PLATFORM_INTR_LEN = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     mstatus,
  input  logic [INTR_LEN-1:0] mie,
  input  logic [INTR_LEN-1:0] mip,
  input  logic [XLEN-1:0]     mtvec,
  input  logic [ALEN-1:0]     mepc,
  input  logic [1:0]          privilege_mode,
  input  logic                exc_valid,
  input  logic [3:0]          exc_cause,
  input  logic [ALEN-1:0]     exc_pc,
  input  logic [XLEN-1:0]     exc_tval,
  input  logic                mret_valid,
  input  logic [ALEN-1:0]     next_pc,
  output logic                exc_ack,
  output logic                flush_req,
  input  logic                pipeline_empty,
  output logic                trap_do_update,
  output logic [XLEN-1:0]     trap_mcause,
  output logic [ALEN-1:0]     trap_mepc,
  output logic [XLEN-1:0]     trap_mtval,
  output logic                xret_do_update,
  output logic                xret_completing,
  output logic [XLEN-1:0]     xret_new_mstatus,
  output logic [1:0]          xret_new_privilege_mode,
  output logic                redirect_valid,
  output logic [ALEN-1:0]     redirect_pc,
  input  logic                redirect_ready
);

  localparam int IDX_W     = $clog2(INTR_LEN);
  localparam int PLAT_LAST = 16 + PLATFORM_INTR_LEN - 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DRAIN    = 3'd1;
  localparam logic [2:0] S_UPDATE   = 3'd2;
  localparam logic [2:0] S_CHAIN    = 3'd3;
  localparam logic [2:0] S_REDIRECT = 3'd4;

  logic [2:0]       r_state;
  logic             r_is_xret;
  logic             r_is_intr;
  logic [IDX_W-1:0] r_idx;
  logic [XLEN-1:0]  r_mcause;
  logic [ALEN-1:0]  r_mepc;
  logic [XLEN-1:0]  r_mtval;
  logic [ALEN-1:0]  r_redirect_pc;
  logic             r_exc_ack;

  logic [INTR_LEN-1:0] w_pend;
  logic                w_int_en;
  logic                w_intr_hit;
  logic [IDX_W-1:0]    w_intr_idx;
  logic [XLEN-1:0]     w_intr_mcause;
  logic [ALEN-1:0]     w_tvec_base;
  logic [ALEN-1:0]     w_intr_vec;
  logic [ALEN-1:0]     w_trap_vec;
  logic [XLEN-1:0]     w_mret_mstatus;
  logic                w_chain;
  logic                w_unused;

  assign w_pend   = mip & mie;
  assign w_int_en = mstatus[3] | (privilege_mode != 2'b11);

  // Priority: MEI(11) > MSI(3) > MTI(7) > platform lines, lowest index first.
  // The platform scan runs high-to-low so the lowest pending index is the
  // last writer; the three standard lines then override in reverse priority.
  always_comb begin
    w_intr_hit = 1'b0;
    w_intr_idx = '0;
    for (int i = PLAT_LAST; i >= 16; i--) begin
      if (w_pend[i]) begin
        w_intr_hit = 1'b1;
        w_intr_idx = IDX_W'(i);
      end
    end
    if (w_pend[7]) begin
      w_intr_hit = 1'b1;
      w_intr_idx = IDX_W'(7);
    end
    if (w_pend[3]) begin
      w_intr_hit = 1'b1;
      w_intr_idx = IDX_W'(3);
    end
    if (w_pend[11]) begin
      w_intr_hit = 1'b1;
      w_intr_idx = IDX_W'(11);
    end
  end

  assign w_intr_mcause = {1'b1, {(XLEN-1-IDX_W){1'b0}}, w_intr_idx};
  assign w_tvec_base   = {mtvec[ALEN-1:2], 2'b00};

  // Vector offset for a freshly arbitrated interrupt (used by the MRET chain).
  assign w_intr_vec = w_tvec_base +
                      (mtvec[0] ? {{(ALEN-IDX_W-2){1'b0}}, w_intr_idx, 2'b00} : '0);

  // Vector for the captured trap; only interrupts are vectored.
  assign w_trap_vec = w_tvec_base +
                      ((mtvec[0] && r_is_intr) ? {{(ALEN-IDX_W-2){1'b0}}, r_idx, 2'b00} : '0);

  always_comb begin
    w_mret_mstatus        = mstatus;
    w_mret_mstatus[3]     = mstatus[7];
    w_mret_mstatus[7]     = 1'b1;
    w_mret_mstatus[12:11] = 2'b11;
  end

  // After MRET the new MIE is the old MPIE; M-mode is the only mode so the
  // interrupt is takeable whenever that bit is set and something is pending.
  assign w_chain = mstatus[7] & w_intr_hit;

  assign w_unused = ^{mtvec[1], w_pend[15:12], w_pend[10:8], w_pend[6:4], w_pend[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_is_xret     <= 1'b0;
      r_is_intr     <= 1'b0;
      r_idx         <= '0;
      r_mcause      <= '0;
      r_mepc        <= '0;
      r_mtval       <= '0;
      r_redirect_pc <= '0;
      r_exc_ack     <= 1'b0;
    end else begin
      r_exc_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (exc_valid) begin
            r_mcause  <= {{(XLEN-4){1'b0}}, exc_cause};
            r_mepc    <= exc_pc;
            r_mtval   <= exc_tval;
            r_is_intr <= 1'b0;
            r_is_xret <= 1'b0;
            r_exc_ack <= 1'b1;
            r_state   <= S_DRAIN;
          end else if (w_int_en && w_intr_hit) begin
            // Cause captured here, so a line dropping during DRAIN is still taken.
            r_mcause  <= w_intr_mcause;
            r_mepc    <= next_pc;
            r_mtval   <= '0;
            r_idx     <= w_intr_idx;
            r_is_intr <= 1'b1;
            r_is_xret <= 1'b0;
            r_state   <= S_DRAIN;
          end else if (mret_valid) begin
            r_is_intr <= 1'b0;
            r_is_xret <= 1'b1;
            r_exc_ack <= 1'b1;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pipeline_empty) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (r_is_xret) begin
            if (w_chain) begin
              // mepc keeps the value MRET returned to; trap values for CHAIN.
              r_mcause      <= w_intr_mcause;
              r_mepc        <= mepc;
              r_mtval       <= '0;
              r_idx         <= w_intr_idx;
              r_is_intr     <= 1'b1;
              r_redirect_pc <= w_intr_vec;
              r_state       <= S_CHAIN;
            end else begin
              r_redirect_pc <= mepc;
              r_state       <= S_REDIRECT;
            end
          end else begin
            r_redirect_pc <= w_trap_vec;
            r_state       <= S_REDIRECT;
          end
        end
        S_CHAIN: begin
          r_state <= S_REDIRECT;
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode from the state register, so an async reset clears them
  // immediately and each lasts exactly the one cycle spent in its state.
  assign exc_ack         = r_exc_ack;
  assign flush_req       = (r_state != S_IDLE);
  assign trap_do_update  = ((r_state == S_UPDATE) && !r_is_xret) || (r_state == S_CHAIN);
  assign xret_do_update  = (r_state == S_UPDATE) && r_is_xret;
  assign xret_completing = (r_state == S_CHAIN);
  assign trap_mcause     = r_mcause;
  assign trap_mepc       = r_mepc;
  assign trap_mtval      = r_mtval;
  assign redirect_valid  = (r_state == S_REDIRECT);
  assign redirect_pc     = r_redirect_pc;

  assign xret_new_mstatus        = xret_do_update ? w_mret_mstatus : '0;
  assign xret_new_privilege_mode = xret_do_update ? mstatus[12:11] : 2'b00;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//   Directed test-plan vectors followed by randomized transactions, each
//   checked against a behavioural prediction of trap/MRET outcomes.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] mstatus, mie, mip, mtvec, mepc;
  logic [1:0]  privilege_mode;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [63:0] exc_pc, exc_tval;
  logic        mret_valid;
  logic [63:0] next_pc;
  logic        exc_ack, flush_req, pipeline_empty;
  logic        trap_do_update;
  logic [63:0] trap_mcause, trap_mepc, trap_mtval;
  logic        xret_do_update, xret_completing;
  logic [63:0] xret_new_mstatus;
  logic [1:0]  xret_new_privilege_mode;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;

  int checks   = 0;
  int failures = 0;

  // prediction
  bit          e_none, e_ack, e_trap, e_xret, e_chain;
  logic [63:0] e_mcause, e_mepc, e_mtval, e_redir, e_mst;
  logic [1:0]  e_priv;
  int          prio[$];

  // observation
  logic [63:0] ob_mcause, ob_mepc, ob_mtval, ob_redir, ob_mst;
  logic [1:0]  ob_priv;
  logic        ob_compl;

  trap_ctrl dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .mstatus                 (mstatus),
    .mie                     (mie),
    .mip                     (mip),
    .mtvec                   (mtvec),
    .mepc                    (mepc),
    .privilege_mode          (privilege_mode),
    .exc_valid               (exc_valid),
    .exc_cause               (exc_cause),
    .exc_pc                  (exc_pc),
    .exc_tval                (exc_tval),
    .mret_valid              (mret_valid),
    .next_pc                 (next_pc),
    .exc_ack                 (exc_ack),
    .flush_req               (flush_req),
    .pipeline_empty          (pipeline_empty),
    .trap_do_update          (trap_do_update),
    .trap_mcause             (trap_mcause),
    .trap_mepc               (trap_mepc),
    .trap_mtval              (trap_mtval),
    .xret_do_update          (xret_do_update),
    .xret_completing         (xret_completing),
    .xret_new_mstatus        (xret_new_mstatus),
    .xret_new_privilege_mode (xret_new_privilege_mode),
    .redirect_valid          (redirect_valid),
    .redirect_pc             (redirect_pc),
    .redirect_ready          (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Outcome predicted from the architectural rules for the current inputs.
  task automatic predict();
    logic [63:0] pend;
    logic [63:0] base;
    int          win;
    pend = mip & mie;
    win  = -1;
    foreach (prio[k]) if (win < 0 && pend[prio[k]]) win = prio[k];
    base = mtvec & ~64'd3;
    e_none = 0; e_ack = 0; e_trap = 0; e_xret = 0; e_chain = 0;
    e_mcause = 0; e_mepc = 0; e_mtval = 0; e_redir = 0; e_mst = 0; e_priv = 0;
    if (exc_valid) begin
      e_ack = 1; e_trap = 1;
      e_mcause = {60'd0, exc_cause}; e_mepc = exc_pc; e_mtval = exc_tval;
      e_redir = base;
    end else if ((mstatus[3] || privilege_mode != 2'b11) && win >= 0) begin
      e_trap = 1;
      e_mcause = (64'd1 << 63) | 64'(win); e_mepc = next_pc; e_mtval = 0;
      e_redir = base + (mtvec[0] ? 64'(win) * 4 : 64'd0);
    end else if (mret_valid) begin
      e_ack = 1; e_xret = 1;
      e_mst = mstatus;
      e_mst[3] = mstatus[7];
      e_mst[7] = 1'b1;
      e_mst[12:11] = 2'b11;
      e_priv = mstatus[12:11];
      e_redir = mepc;
      if (mstatus[7] && win >= 0) begin
        e_chain = 1; e_trap = 1;
        e_mcause = (64'd1 << 63) | 64'(win); e_mepc = mepc; e_mtval = 0;
        e_redir = base + (mtvec[0] ? 64'(win) * 4 : 64'd0);
      end
    end else begin
      e_none = 1;
    end
  endtask

  task automatic clear_req();
    exc_valid = 0; mret_valid = 0; mie = 0; mip = 0;
    pipeline_empty = 0; redirect_ready = 0;
  endtask

  // One transaction from request to the return to IDLE.
  task automatic run_txn(input int empty_dly, input int bp);
    int cyc, drain, rv_cyc, n_ack, n_trap, n_xret, trap_cyc, xret_cyc, unstable, n_flush;
    bit done, acc;
    predict();
    pipeline_empty = 0; redirect_ready = 0;
    cyc = 0; drain = 0; rv_cyc = 0; n_ack = 0; n_trap = 0; n_xret = 0;
    trap_cyc = 0; xret_cyc = 0; unstable = 0; n_flush = 0; done = 0; acc = 0;
    ob_mcause = 'x; ob_mepc = 'x; ob_mtval = 'x; ob_redir = 'x; ob_mst = 'x; ob_priv = 'x; ob_compl = 'x;
    if (e_none) begin
      repeat (8) begin
        @(negedge clk);
        if (flush_req || exc_ack || trap_do_update || xret_do_update) n_flush++;
      end
      chk("no_trap_activity", 64'(n_flush), 64'd0);
      $display("txn none: activity_cycles=%0d", n_flush);
      clear_req();
      return;
    end
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        done = 1;
        redirect_ready = 0;
        chk("flush_drop", 64'(flush_req), 64'd0);
        chk("rv_drop", 64'(redirect_valid), 64'd0);
      end else begin
        if (exc_ack) begin n_ack++; exc_valid = 0; mret_valid = 0; end
        if (flush_req) drain++;
        pipeline_empty = (drain > empty_dly);
        if (trap_do_update) begin
          n_trap++; trap_cyc = cyc;
          ob_mcause = trap_mcause; ob_mepc = trap_mepc; ob_mtval = trap_mtval;
          ob_compl = xret_completing;
        end
        if (xret_do_update) begin
          n_xret++; xret_cyc = cyc;
          ob_mst = xret_new_mstatus; ob_priv = xret_new_privilege_mode;
        end
        if (redirect_valid) begin
          if (rv_cyc == 0) ob_redir = redirect_pc;
          else if (redirect_pc !== ob_redir) unstable++;
          rv_cyc++;
          if (rv_cyc > bp) begin redirect_ready = 1; acc = 1; end
        end
      end
    end
    chk("completed", 64'(done), 64'd1);
    chk("ack_pulses", 64'(n_ack), 64'(e_ack));
    chk("trap_pulses", 64'(n_trap), 64'(e_trap));
    chk("xret_pulses", 64'(n_xret), 64'(e_xret));
    if (e_trap) begin
      chk("mcause", ob_mcause, e_mcause);
      chk("mepc", ob_mepc, e_mepc);
      chk("mtval", ob_mtval, e_mtval);
      chk("xret_completing", 64'(ob_compl), 64'(e_chain));
    end
    if (e_xret) begin
      chk("new_mstatus", ob_mst, e_mst);
      chk("new_priv", 64'(ob_priv), 64'(e_priv));
    end
    if (e_chain) chk("chain_follows_xret", 64'(trap_cyc - xret_cyc), 64'd1);
    chk("redirect_pc", ob_redir, e_redir);
    chk("redirect_stable", 64'(unstable), 64'd0);
    chk("redirect_cycles", 64'(rv_cyc), 64'(bp + 1));
    $display("txn ack=%0d trap=%0d xret=%0d chain=%0b mcause=0x%h mepc=0x%h redir=0x%h cycles=%0d",
             n_ack, n_trap, n_xret, e_chain, ob_mcause, ob_mepc, ob_redir, cyc);
    clear_req();
  endtask

  initial begin
    bit          seen;
    logic [63:0] exp_pc;
    int          kind;

    prio = {11, 3, 7};
    for (int i = 16; i < 64; i++) prio.push_back(i);

    rst_n = 0;
    mstatus = 0; mtvec = 0; mepc = 0; privilege_mode = 2'b11;
    exc_cause = 0; exc_pc = 0; exc_tval = 0; next_pc = 0;
    clear_req();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_flush", 64'(flush_req), 64'd0);
    chk("rst_ack", 64'(exc_ack), 64'd0);
    chk("rst_trap", 64'(trap_do_update), 64'd0);
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    chk("rst_mcause", trap_mcause, 64'd0);
    rst_n = 1;
    @(negedge clk);

    // Illegal instruction
    mtvec = 64'h8000_0100;
    exc_valid = 1; exc_cause = 4'd2; exc_pc = 64'h8000_0010; exc_tval = 64'h1234;
    run_txn(3, 0);
    chk("ill_mcause", ob_mcause, 64'd2);
    chk("ill_mepc", ob_mepc, 64'h8000_0010);
    chk("ill_mtval", ob_mtval, 64'h1234);
    chk("ill_redir", ob_redir, 64'h8000_0100);

    // Vectored MTI
    mtvec = 64'h8000_0101; mstatus = 64'h8; privilege_mode = 2'b11;
    mie = 64'h80; mip = 64'h80; next_pc = 64'h8000_0040;
    run_txn(1, 0);
    chk("mti_mcause", ob_mcause, 64'h8000_0000_0000_0007);
    chk("mti_mepc", ob_mepc, 64'h8000_0040);
    chk("mti_redir", ob_redir, 64'h8000_011C);

    // Priority among 3, 7, 11, 17
    mtvec = 64'h8000_0100; mstatus = 64'h8;
    mie = 64'h2_0888; mip = 64'h2_0888;
    run_txn(2, 1);
    chk("prio_mcause", ob_mcause, 64'h8000_0000_0000_000B);

    // Same pending set, interrupts disabled in M-mode
    mstatus = 64'h0; mie = 64'h2_0888; mip = 64'h2_0888;
    run_txn(0, 0);

    // Plain MRET
    mstatus = 64'h80; privilege_mode = 2'b11; mepc = 64'h8000_0200;
    mie = 0; mip = 0; mret_valid = 1;
    run_txn(2, 0);
    chk("mret_mstatus", ob_mst, 64'h1888);
    chk("mret_priv", 64'(ob_priv), 64'd0);
    chk("mret_redir", ob_redir, 64'h8000_0200);

    // MRET followed by chained MEI
    mstatus = 64'h80; mepc = 64'h8000_0200; mtvec = 64'h8000_0100;
    mie = 64'h800; mip = 64'h800; mret_valid = 1;
    run_txn(1, 0);
    chk("chain_mepc", ob_mepc, 64'h8000_0200);
    chk("chain_mcause", ob_mcause, 64'h8000_0000_0000_000B);
    chk("chain_compl", 64'(ob_compl), 64'd1);
    chk("chain_redir", ob_redir, 64'h8000_0100);

    // Backpressure then reset mid-REDIRECT
    mtvec = 64'h8000_0300; exc_valid = 1; exc_cause = 4'd5;
    exc_pc = 64'h8000_0044; exc_tval = 64'h55; pipeline_empty = 1;
    exp_pc = mtvec & ~64'd3;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (exc_ack) exc_valid = 0;
      if (redirect_valid) seen = 1;
    end
    chk("bp_reached", 64'(seen), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(redirect_valid), 64'd1);
      chk("bp_pc", redirect_pc, exp_pc);
    end
    #2 rst_n = 0;
    #1;
    chk("arst_rv", 64'(redirect_valid), 64'd0);
    chk("arst_flush", 64'(flush_req), 64'd0);
    chk("arst_rpc", redirect_pc, 64'd0);
    chk("arst_mcause", trap_mcause, 64'd0);
    chk("arst_strobes", 64'({trap_do_update, xret_do_update, exc_ack}), 64'd0);
    $display("txn async reset in REDIRECT: rv=%0b flush=%0b", redirect_valid, flush_req);
    clear_req();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_idle", 64'(flush_req), 64'd0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      mtvec = rnd64(); mepc = rnd64(); next_pc = rnd64();
      mstatus = rnd64(); privilege_mode = 2'($urandom_range(0, 3));
      mie = rnd64() & rnd64(); mip = rnd64() & rnd64();
      if ($urandom_range(0, 3) == 0) mip = mip & 64'hFFFF;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        exc_valid = 1; exc_cause = 4'($urandom); exc_pc = rnd64(); exc_tval = rnd64();
      end else if (kind == 2) begin
        mstatus[3] = 1'b0; privilege_mode = 2'b11; mret_valid = 1;
        if ($urandom_range(0, 1) == 0) mip = 0;
      end
      run_txn($urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequencer for machine-mode trap entry and MRET in the core's exec stage.
- Arbitrates between synchronous exceptions, pending interrupts (mip & mie) and MRET requests.
- Drains the pipeline, drives the one-cycle trap/xret update strobes into the CSR file, then issues a fetch redirect with a valid/ready handshake.
- Single-hart, M-mode only.

Parameters:
XLEN, 64, data/CSR width
ALEN, 64, address width (mepc, PCs)
INTR_LEN, 64, width of mie/mip
PLATFORM_INTR_LEN, 48, platform interrupt lines, occupying mip[INTR_LEN-1:16]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mstatus  in  XLEN  current mstatus (MIE bit 3, MPIE bit 7, MPP bits 12:11)
mie  in  INTR_LEN  current mie
mip  in  INTR_LEN  current mip
mtvec  in  XLEN  current mtvec (bit 0 = vectored mode)
mepc  in  ALEN  current mepc
privilege_mode  in  2  current privilege
exc_valid  in  1  exception request from exec, held until exc_ack
exc_cause  in  4  exception code
exc_pc  in  ALEN  PC of faulting instruction
exc_tval  in  XLEN  mtval value for the exception
mret_valid  in  1  MRET request, held until exc_ack
next_pc  in  ALEN  PC of oldest non-retired instruction (interrupt mepc)
exc_ack  out  1  one-cycle pulse: exception or MRET accepted
flush_req  out  1  stop issue and drain pipeline
pipeline_empty  in  1  no instructions in flight
trap_do_update  out  1  one-cycle CSR trap strobe
trap_mcause  out  XLEN  mcause to write
trap_mepc  out  ALEN  mepc to write
trap_mtval  out  XLEN  mtval to write
xret_do_update  out  1  one-cycle CSR MRET strobe
xret_completing  out  1  trap taken immediately after MRET; CSR file keeps mepc
xret_new_mstatus  out  XLEN  mstatus after MRET
xret_new_privilege_mode  out  2  privilege after MRET
redirect_valid  out  1  fetch redirect request
redirect_pc  out  ALEN  redirect target
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (rst_n low, async): state IDLE. All strobes, flush_req, exc_ack and redirect_valid are 0. Captured cause, pc, tval and redirect_pc are 0.
- Interrupt enable: int_en = mstatus[3] | (privilege_mode != 2'b11). Pending set: pend = mip & mie.
- Interrupt priority, highest first: bit 11 (MEI), bit 3 (MSI), bit 7 (MTI), then platform bits 16..INTR_LEN-1 with the lowest index winning.
- Interrupt mcause = {1'b1, zero-extended index}.
- Arbitration in IDLE, priority order:
  - exc_valid: capture exc_cause zero-extended into mcause (bit XLEN-1 = 0), exc_pc, exc_tval. Pulse exc_ack. Go to DRAIN.
  - else int_en && |pend: capture mcause, next_pc, tval = 0. Go to DRAIN. No exc_ack.
  - else mret_valid: pulse exc_ack. Go to DRAIN, kind = XRET.
  - else stay in IDLE.
- DRAIN: flush_req = 1. Stay until pipeline_empty = 1, then go to UPDATE.
- An interrupt that deasserts during DRAIN is still taken, since its cause was captured.
- UPDATE (one cycle, flush_req held):
  - Trap: trap_do_update = 1.
  - XRET: xret_do_update = 1.
    - xret_new_mstatus = mstatus with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
    - xret_new_privilege_mode = mstatus[12:11].
    - redirect_pc = mepc.
  - Trap target: redirect_pc = {mtvec[XLEN-1:2], 2'b00}, plus 4*index when mtvec[0] = 1 and the cause is an interrupt.
- Then go to REDIRECT, except for an XRET when new MIE = 1 and |pend. In that case go to CHAIN.
- CHAIN (one cycle): re-arbitrate interrupts only.
  - trap_do_update = 1 and xret_completing = 1.
  - trap_mepc = mepc value written by MRET (unchanged).
  - redirect_pc = trap vector.
  - Go to REDIRECT.
- REDIRECT: redirect_valid = 1 with redirect_pc stable and flush_req held. On redirect_ready, go to IDLE; flush_req drops the next cycle.
- Requests arriving outside IDLE are not acked; they are re-arbitrated in IDLE.
- Async reset mid-sequence returns to IDLE immediately with no strobe.
- Strobes are never asserted for more than one cycle per event.

Test Plan:
- Illegal instruction: exc_valid, cause 2, exc_pc 0x8000_0010, tval 0x1234, mtvec 0x8000_0100, pipeline_empty after 3 cycles -> exc_ack 1 cycle; trap_do_update once with mcause 2, mepc 0x8000_0010, mtval 0x1234; redirect_pc 0x8000_0100.
- Vectored MTI: mtvec 0x8000_0101, mie[7] = mip[7] = 1, MIE = 1, next_pc 0x8000_0040 -> mcause 0x8000_0000_0000_0007, mepc 0x8000_0040, redirect_pc 0x8000_011C.
- Priority: mip/mie bits 3, 7, 11 and 17 all set -> mcause index 11. With MIE = 0 in M-mode and no exception -> no trap, stays IDLE.
- MRET: mstatus MPIE = 1, MIE = 0, mepc 0x8000_0200, no pending -> xret_do_update once; new mstatus MIE = 1, MPIE = 1, MPP = 11; redirect_pc 0x8000_0200.
- MRET chain: same as the MRET case but mip[11] = mie[11] = 1 -> xret_do_update, then next cycle trap_do_update with xret_completing = 1, mepc 0x8000_0200, mcause index 11, redirect_pc = mtvec.
- Redirect backpressure plus reset: hold redirect_ready = 0 for 5 cycles -> redirect_valid and redirect_pc stable. Drop rst_n mid-REDIRECT -> all outputs 0 asynchronously.
